dmem_responder: RTL and testbench

Multi-cycle data-memory responder: the target end of the CPU's MEM-stage load/store interface (driven from the EX/MEM pipeline register). It accepts one word-aligned read or write at a time, models a fixed access latency, and holds the pipeline with `stall_o` until the access completes. On completion it presents read data for MEM/WB capture and pulses `ack_o`.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
// Holds the responder FSM state type, the bytes-per-word constant and the
// latency counter width. No ports.
package dmem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x 32 word storage, sync write / async read
// Ports:
//   clk_i   - clock; writes commit on its rising edge
//   we_i    - write enable
//   waddr_i - write word index
//   wdata_i - write data
//   raddr_i - read word index
//   rdata_o - read data (combinational)
// Contents are deliberately not reset.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle MEM-stage load/store responder
// Ports:
//   clk_i      - clock
//   rst_i      - synchronous active-high reset
//   MemRead_i  - load request (held while stall_o)
//   MemWrite_i - store request (held while stall_o)
//   addr_i     - byte address, word index addr_i[31:2]
//   data_i     - store data
//   data_o     - registered load data, held between loads
//   ack_o      - one-cycle completion pulse
//   err_o      - rejected request, valid with ack_o
//   stall_o    - pipeline freeze, combinational
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int               AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0]      DEPTH_W  = 30'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam int               ADDR_LSB = $clog2(WORD_BYTES);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      data_q;
    logic             ack_q;
    logic             err_q;

    logic             req;
    logic             illegal;
    logic             busy_last;
    logic             idle_direct;
    logic             mem_we;
    logic [AW-1:0]    word_idx;
    logic [31:0]      rdata;

    assign req = MemRead_i | MemWrite_i;

    assign illegal = (MemRead_i & MemWrite_i)
                   | (addr_i[ADDR_LSB-1:0] != '0)
                   | (addr_i[31:ADDR_LSB] >= DEPTH_W);

    assign word_idx = addr_i[AW+ADDR_LSB-1:ADDR_LSB];
    assign cnt_d    = cnt_q - CNT_W'(1);

    // The access happens on the edge where the count reaches zero, so the
    // completing BUSY cycle is the one holding 1 (0 is treated the same as a
    // guard against wrap).
    assign busy_last   = (state_q == ST_BUSY) && (cnt_q <= CNT_LAST);
    assign idle_direct = (state_q == ST_IDLE) && req && !illegal && (LATENCY == 1);

    // Reset wins over a commit in the same edge so an interrupted store never
    // lands in the array.
    assign mem_we = (busy_last | idle_direct) & MemWrite_i & ~rst_i;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (word_idx),
        .wdata_i (data_i),
        .raddr_i (word_idx),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (illegal) begin
                            state_q <= ST_DONE;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (LATENCY == 1) begin
                            state_q <= ST_DONE;
                            ack_q   <= 1'b1;
                            if (!MemWrite_i) begin
                                data_q <= rdata;
                            end
                        end else begin
                            state_q <= ST_BUSY;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt_q <= (cnt_q == '0) ? '0 : cnt_d;
                    if (busy_last) begin
                        state_q <= ST_DONE;
                        ack_q   <= 1'b1;
                        // A dropped request still completes; only a held
                        // store turns it into a write.
                        if (!MemWrite_i) begin
                            data_q <= rdata;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall_o = ((state_q == ST_IDLE) & req) | (state_q == ST_BUSY);
    assign data_o  = data_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (LATENCY 4 and 1)
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    int          sel;
    logic        rd_c, wr_c;
    logic [31:0] addr_c, wdata_c;

    logic        rd4, wr4, rd1, wr1;
    logic [31:0] data4, data1;
    logic        ack4, err4, stall4, ack1, err1, stall1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mdl_mem  [2][256];
    bit          mdl_vld  [2][256];
    logic [31:0] mdl_data [2];

    always #5 clk = ~clk;

    assign rd4 = rd_c & (sel == 0);
    assign wr4 = wr_c & (sel == 0);
    assign rd1 = rd_c & (sel == 1);
    assign wr1 = wr_c & (sel == 1);

    dmem_responder #(.DEPTH(256), .LATENCY(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .MemRead_i(rd4), .MemWrite_i(wr4),
        .addr_i(addr_c), .data_i(wdata_c), .data_o(data4),
        .ack_o(ack4), .err_o(err4), .stall_o(stall4)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .MemRead_i(rd1), .MemWrite_i(wr1),
        .addr_i(addr_c), .data_i(wdata_c), .data_o(data1),
        .ack_o(ack1), .err_o(err1), .stall_o(stall1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sel_data(input int s);
        return (s == 1) ? data1 : data4;
    endfunction

    function automatic logic [2:0] sel_flags(input int s);
        return (s == 1) ? {ack1, err1, stall1} : {ack4, err4, stall4};
    endfunction

    // One complete access: drive, expect stall for the rule-derived number of
    // cycles, then the ack cycle with error flag and load data from the model.
    task automatic access(input int s, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input string tag);
        bit bad;
        int exp_cyc;
        int idx;
        bad     = (rd && wr) || (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd256);
        exp_cyc = bad ? 1 : ((s == 1) ? 1 : 4);
        idx     = int'(addr[9:2]);
        @(negedge clk);
        sel = s; rd_c = rd; wr_c = wr; addr_c = addr; wdata_c = wdata;
        for (int c = 0; c < exp_cyc; c++) begin
            #1;
            check({tag, "_stall"}, {29'b0, sel_flags(s)}, 32'b001);
            @(negedge clk);
        end
        if (!bad && wr) begin
            mdl_mem[s][idx] = wdata;
            mdl_vld[s][idx] = 1'b1;
        end
        if (!bad && rd) mdl_data[s] = mdl_mem[s][idx];
        #1;
        check({tag, "_ack"}, {29'b0, sel_flags(s)}, {29'b0, 1'b1, bad, 1'b0});
        check({tag, "_data"}, sel_data(s), mdl_data[s]);
    endtask

    task automatic idle(input int n, input string tag);
        @(negedge clk);
        rd_c = 1'b0; wr_c = 1'b0;
        for (int c = 0; c < n; c++) begin
            #1;
            check({tag, "_flags4"}, {29'b0, ack4, err4, stall4}, 32'b0);
            check({tag, "_flags1"}, {29'b0, ack1, err1, stall1}, 32'b0);
            check({tag, "_data4"}, data4, mdl_data[0]);
            check({tag, "_data1"}, data1, mdl_data[1]);
            @(negedge clk);
        end
    endtask

    initial begin
        int          s, kind, word;
        logic        rd, wr;
        logic [31:0] addr;

        rst = 1'b1; sel = 0; rd_c = 1'b0; wr_c = 1'b0; addr_c = '0; wdata_c = '0;
        mdl_data[0] = '0; mdl_data[1] = '0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) mdl_vld[d][i] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_flags4", {29'b0, ack4, err4, stall4}, 32'b0);
        check("rst_flags1", {29'b0, ack1, err1, stall1}, 32'b0);
        check("rst_data4", data4, 32'b0);
        check("rst_data1", data1, 32'b0);

        // Directed scenarios
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "l4_wr10");
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, "l4_rd10");
        access(1, 1'b0, 1'b1, 32'h0, 32'h12345678, "l1_wr0");
        access(1, 1'b1, 1'b0, 32'h0, 32'h0, "l1_rd0");
        access(0, 1'b1, 1'b0, 32'h6, 32'h0, "misalign");
        access(0, 1'b0, 1'b1, 32'h0, 32'h01020304, "l4_wr0");
        access(0, 1'b0, 1'b1, 32'h400, 32'hBAD0BAD0, "oor_wr");
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, "oor_chk");
        access(0, 1'b1, 1'b1, 32'h0, 32'hBAD1BAD1, "both");
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, "both_chk");
        access(1, 1'b1, 1'b1, 32'h0, 32'hBAD2BAD2, "l1_both");
        access(1, 1'b1, 1'b0, 32'h0, 32'h0, "l1_both_chk");
        idle(20, "idle");

        // Reset in cycle 2 of a store
        access(0, 1'b0, 1'b1, 32'h20, 32'h11112222, "pre_wr20");
        @(negedge clk);
        sel = 0; rd_c = 1'b0; wr_c = 1'b1; addr_c = 32'h20; wdata_c = 32'hAAAA5555;
        #1;
        check("mid_stall0", {31'b0, stall4}, 32'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; wr_c = 1'b0;
        mdl_data[0] = '0; mdl_data[1] = '0;
        #1;
        check("mid_rst_flags", {29'b0, ack4, err4, stall4}, 32'b0);
        check("mid_rst_data", data4, 32'b0);
        idle(4, "post_rst");
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, "post_rst_rd20");

        // Randomized back-to-back traffic against the model
        for (int it = 0; it < 60; it++) begin
            s    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            word = int'($urandom_range(0, 15));
            addr = 32'(word * 4);
            rd   = 1'b0;
            wr   = 1'b1;
            if (kind >= 4 && kind < 8 && mdl_vld[s][word]) begin
                rd = 1'b1; wr = 1'b0;
            end else if (kind == 8) begin
                addr = addr | 32'($urandom_range(1, 3));
                rd   = 1'($urandom_range(0, 1));
                wr   = ~rd;
            end else if (kind == 9) begin
                if ($urandom_range(0, 1) == 0) begin
                    addr = 32'((256 + $urandom_range(0, 1000)) * 4);
                    rd   = 1'($urandom_range(0, 1));
                    wr   = ~rd;
                end else begin
                    rd = 1'b1; wr = 1'b1;
                end
            end
            access(s, rd, wr, addr, $urandom, "rand");
        end
        idle(3, "final_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
